// File: rtl/lsu_pkg.sv
// Shared load/store definitions: FSM states, error codes, funct3 encodings and the
// accept-time legality checks.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } lsu_err_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores have no unsigned forms, so any funct3 past SW is illegal for them.
   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store) return (f3 > F3_W);
      return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      if (f3 == F3_H || f3 == F3_HU) return off[0];
      if (f3 == F3_W) return (off != 2'b00);
      return 1'b0;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side op/result bundle and data-memory req/gnt/rvalid bundle for the LSU.
interface lsu_op_if #(parameter int XLEN = 32);
   logic            op_valid;
   logic            op_ready;
   logic            op_store;
   logic [2:0]      op_funct3;
   logic [XLEN-1:0] op_base;
   logic [11:0]     op_imm;
   logic [XLEN-1:0] op_wdata;
   logic [4:0]      op_rd;
   logic            res_valid;
   logic [4:0]      res_rd;
   logic [XLEN-1:0] res_data;
   logic [1:0]      res_err;

   modport master (
      output op_valid, op_store, op_funct3, op_base, op_imm, op_wdata, op_rd,
      input  op_ready, res_valid, res_rd, res_data, res_err
   );
   modport slave (
      input  op_valid, op_store, op_funct3, op_base, op_imm, op_wdata, op_rd,
      output op_ready, res_valid, res_rd, res_data, res_err
   );
endinterface

interface lsu_mem_if #(parameter int XLEN = 32, parameter int AW = 32);
   logic              mem_req;
   logic              mem_gnt;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [XLEN/8-1:0] mem_be;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated store data from size/offset,
// and shift plus sign/zero extension of returned load data.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        funct3_i,
   input  logic [1:0]        off_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [XLEN-1:0]   rdata_i,
   output logic [XLEN/8-1:0] be_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic [XLEN-1:0]   ldata_o
);

   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] shifted;
   logic            sext;

   always_comb begin
      shifted = rdata_i >> {off_i, 3'b000};
      sext    = !funct3_i[2];
      be_o    = '1;
      wdata_o = wdata_i;
      ldata_o = shifted;
      case (funct3_i[1:0])
         F3_B[1:0]: begin
            be_o    = NB'(1) << off_i;
            wdata_o = {NB{wdata_i[7:0]}};
            ldata_o = {{(XLEN-8){shifted[7] & sext}}, shifted[7:0]};
         end
         F3_H[1:0]: begin
            be_o    = NB'(3) << off_i;
            wdata_o = {(NB/2){wdata_i[15:0]}};
            ldata_o = {{(XLEN-16){shifted[15] & sext}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one op in flight, req/gnt/rvalid memory port,
// one-cycle writeback pulse with error code.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input logic        clk,
   input logic        nreset,
   lsu_op_if.slave    op,
   lsu_mem_if.master  mem
);

   localparam int CW = $clog2(TIMEOUT + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [2:0]      f3_q, f3_d;
   logic            store_q, store_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [4:0]      rd_q, rd_d;
   lsu_err_e        err_q, err_d;
   logic [XLEN-1:0] rdata_q, rdata_d;

   logic [XLEN-1:0]   ea;
   logic [AW-1:0]     acc_addr;
   lsu_err_e          acc_err;
   logic [XLEN/8-1:0] lane_be;
   logic [XLEN-1:0]   lane_wdata;
   logic [XLEN-1:0]   lane_ldata;
   logic              in_req, in_resp;

   assign ea       = op.op_base + {{(XLEN-12){op.op_imm[11]}}, op.op_imm};
   assign acc_addr = AW'(ea);

   always_comb begin
      acc_err = ERR_NONE;
      if (f3_illegal(op.op_store, op.op_funct3))
         acc_err = ERR_ILLEGAL;
      else if (f3_misaligned(op.op_funct3, acc_addr[1:0]))
         acc_err = ERR_MISALIGN;
   end

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .funct3_i (f3_q),
      .off_i    (addr_q[1:0]),
      .wdata_i  (wdata_q),
      .rdata_i  (mem.mem_rdata),
      .be_o     (lane_be),
      .wdata_o  (lane_wdata),
      .ldata_o  (lane_ldata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      store_d = store_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (op.op_valid) begin
               addr_d  = acc_addr;
               f3_d    = op.op_funct3;
               store_d = op.op_store;
               wdata_d = op.op_wdata;
               rd_d    = op.op_rd;
               err_d   = acc_err;
               cnt_d   = '0;
               rdata_d = '0;
               state_d = (acc_err == ERR_NONE) ? REQ : RESP;
            end
         end
         // A grant on the last allowed cycle still wins; WAIT then times out at once
         // unless rvalid comes with it.
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (mem.mem_gnt) begin
               state_d = WAIT;
            end else if (cnt_q >= CNT_LAST) begin
               err_d   = ERR_TIMEOUT;
               state_d = RESP;
            end
         end
         WAIT: begin
            if (mem.mem_rvalid) begin
               rdata_d = store_q ? '0 : lane_ldata;
               state_d = RESP;
            end else if (cnt_q >= CNT_LAST) begin
               err_d   = ERR_TIMEOUT;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         f3_q    <= '0;
         store_q <= 1'b0;
         wdata_q <= '0;
         rd_q    <= '0;
         err_q   <= ERR_NONE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         store_q <= store_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs are gated by state so reset clears them without waiting for a clock.
   assign in_req  = (state_q == REQ);
   assign in_resp = (state_q == RESP);

   assign mem.mem_req   = in_req;
   assign mem.mem_we    = in_req & store_q;
   assign mem.mem_addr  = in_req ? {addr_q[AW-1:2], 2'b00} : '0;
   assign mem.mem_be    = in_req ? lane_be : '0;
   assign mem.mem_wdata = (in_req && store_q) ? lane_wdata : '0;

   assign op.op_ready  = (state_q == IDLE);
   assign op.res_valid = in_resp;
   assign op.res_err   = in_resp ? err_q : ERR_NONE;
   assign op.res_rd    = (in_resp && err_q == ERR_NONE && !store_q) ? rd_q : 5'd0;
   assign op.res_data  = (in_resp && err_q == ERR_NONE) ? rdata_q : '0;

endmodule
